// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: requester, memory and status signals of the line arbiter
interface cache_mem_arbiter_if #(parameter int ADDR_WIDTH = 32);
  logic i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [31:0] i_rdata;
  logic i_rvalid;
  logic i_done;
  logic d_req;
  logic d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [31:0] d_wdata;
  logic d_wnext;
  logic [31:0] d_rdata;
  logic d_rvalid;
  logic d_done;
  logic mem_req;
  logic mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic mem_ack;
  logic busy;
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_rdata, i_rvalid, i_done, d_wnext, d_rdata, d_rvalid, d_done,
           mem_req, mem_we, mem_addr, mem_wdata, busy
  );
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_rdata, i_rvalid, i_done, d_wnext, d_rdata, d_rvalid, d_done,
           mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin I/D cache line burst arbiter onto one memory word port
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 8
) (
  input logic clk,
  input logic rst,
  cache_mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(LINE_WORDS);
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_WORDS * 4 - 1);
  typedef enum logic [1:0] {IDLE, I_BURST, D_BURST, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [ADDR_WIDTH-1:0] base;
  logic we_q, owner, last_d;
  logic burst, grantD;
  assign burst = state == I_BURST || state == D_BURST;
  // last_d = 0 after reset, so D wins the first contention
  assign grantD = bus.d_req && (!bus.i_req || !last_d);
  assign bus.mem_req = burst;
  assign bus.mem_we = burst && we_q;
  assign bus.mem_addr = burst ? base + ADDR_WIDTH'({cnt, 2'b00}) : '0;
  assign bus.mem_wdata = burst ? bus.d_wdata : '0;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      base <= '0;
      we_q <= 1'b0;
      owner <= 1'b0;
      last_d <= 1'b0;
      bus.i_rdata <= '0;
      bus.d_rdata <= '0;
      bus.i_rvalid <= 1'b0;
      bus.d_rvalid <= 1'b0;
      bus.d_wnext <= 1'b0;
      bus.i_done <= 1'b0;
      bus.d_done <= 1'b0;
    end else begin
      bus.i_rvalid <= 1'b0;
      bus.d_rvalid <= 1'b0;
      bus.d_wnext <= 1'b0;
      bus.i_done <= 1'b0;
      bus.d_done <= 1'b0;
      case (state)
        IDLE: if (bus.i_req || bus.d_req) begin
          owner <= grantD;
          we_q <= grantD && bus.d_we;
          base <= (grantD ? bus.d_addr : bus.i_addr) & ~OFF_MASK;
          cnt <= '0;
          state <= grantD ? D_BURST : I_BURST;
        end
        I_BURST, D_BURST: if (bus.mem_ack) begin
          cnt <= cnt + CW'(1);
          if (we_q) bus.d_wnext <= 1'b1;
          else if (owner) begin
            bus.d_rdata <= bus.mem_rdata;
            bus.d_rvalid <= 1'b1;
          end else begin
            bus.i_rdata <= bus.mem_rdata;
            bus.i_rvalid <= 1'b1;
          end
          // done strobes are registered here so they land in the DONE cycle
          if (cnt == LAST) begin
            state <= DONE;
            last_d <= owner;
            bus.i_done <= !owner;
            bus.d_done <= owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed tests of the I/D line arbiter against a bench memory
module tb_cache_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int nChk = 0;
  int nFail = 0;
  int ackMode = 1;
  int div = 0;
  logic manualAck = 1'b0;
  logic [135:0] outs;
  cache_mem_arbiter_if #(.ADDR_WIDTH(32)) bus();
  cache_mem_arbiter #(.ADDR_WIDTH(32), .LINE_WORDS(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // memory returns address xor a fixed pattern; ack is zero-wait, every 3rd cycle, or manual
  assign bus.mem_rdata = bus.mem_addr ^ 32'hCAFE_0000;
  assign bus.mem_ack = ackMode == 1 ? bus.mem_req : ackMode == 3 ? (bus.mem_req && div == 2) : manualAck;
  always @(posedge clk) div <= (!bus.mem_req || bus.mem_ack) ? 0 : div + 1;
  assign outs = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.i_rvalid,
                 bus.i_done, bus.d_rdata, bus.d_rvalid, bus.d_wnext, bus.d_done, bus.busy};

  task automatic apply_reset;
    rst = 1'b0;
    bus.i_req = 1'b0;
    bus.i_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    manualAck = 1'b0;
    ackMode = 1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    apply_reset;
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    rst = 1'b0;
    #1;
    nChk++;
    if (outs !== '0) begin nFail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    repeat (2) @(negedge clk);
    nChk++;
    if (outs !== '0) begin nFail++; $display("FAIL reset_held: got %h expected 0", outs); end
  endtask

  task automatic test_i_refill;
    logic expReq, expRv;
    logic [31:0] expAddr;
    apply_reset;
    bus.i_addr = 32'h0000_1234;
    bus.i_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      expReq = c <= 8;
      expAddr = expReq ? 32'h1220 + 32'(4 * (c - 1)) : 32'h0;
      nChk++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {expReq, 1'b0, expAddr}) begin
        nFail++;
        $display("FAIL i_refill_mem c=%0d: got req=%b we=%b addr=%h expected req=%b we=0 addr=%h",
                 c, bus.mem_req, bus.mem_we, bus.mem_addr, expReq, expAddr);
      end
      expRv = c >= 2 && c <= 9;
      nChk++;
      if (bus.i_rvalid !== expRv) begin nFail++; $display("FAIL i_refill_rvalid c=%0d: got %b expected %b", c, bus.i_rvalid, expRv); end
      if (expRv) begin
        nChk++;
        if (bus.i_rdata !== ((32'h1220 + 32'(4 * (c - 2))) ^ 32'hCAFE_0000)) begin
          nFail++;
          $display("FAIL i_refill_rdata c=%0d: got %h expected %h", c, bus.i_rdata, (32'h1220 + 32'(4 * (c - 2))) ^ 32'hCAFE_0000);
        end
      end
      nChk++;
      if ({bus.i_done, bus.busy, bus.d_rvalid, bus.d_done, bus.d_wnext} !== {c == 9, c <= 9, 3'b000}) begin
        nFail++;
        $display("FAIL i_refill_status c=%0d: got done,busy,drv,ddone,wnext=%b%b%b%b%b expected %b%b000",
                 c, bus.i_done, bus.busy, bus.d_rvalid, bus.d_done, bus.d_wnext, c == 9, c <= 9);
      end
      if (c == 9) bus.i_req = 1'b0;
    end
  endtask

  task automatic test_contention;
    logic [31:0] grants[$];
    logic [31:0] expG[4] = '{32'h2000, 32'h3000, 32'h2000, 32'h3000};
    logic prevReq = 1'b0;
    int dRv = 0, iRv = 0, firstDDone = -1, iStart = -1, round = 0;
    bit both = 0;
    apply_reset;
    bus.i_addr = 32'h3004;
    bus.d_addr = 32'h2010;
    bus.d_we = 1'b0;
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    for (int c = 1; c <= 60 && round < 2; c++) begin
      @(negedge clk);
      if (both) begin bus.i_req = 1'b1; bus.d_req = 1'b1; both = 0; end
      if (bus.mem_req && !prevReq) begin
        grants.push_back(bus.mem_addr);
        if (grants.size() == 2) iStart = c;
      end
      prevReq = bus.mem_req;
      if (bus.d_rvalid) begin
        nChk++;
        if (bus.d_rdata !== ((32'h2000 + 32'(4 * (dRv % 8))) ^ 32'hCAFE_0000)) begin
          nFail++; $display("FAIL contention_d_rdata word=%0d: got %h", dRv, bus.d_rdata);
        end
        dRv++;
      end
      if (bus.i_rvalid) begin
        nChk++;
        if (bus.i_rdata !== ((32'h3000 + 32'(4 * (iRv % 8))) ^ 32'hCAFE_0000)) begin
          nFail++; $display("FAIL contention_i_rdata word=%0d: got %h", iRv, bus.i_rdata);
        end
        iRv++;
      end
      if (bus.d_done) begin
        if (firstDDone < 0) firstDDone = c;
        bus.d_req = 1'b0;
      end
      if (bus.i_done) begin
        bus.i_req = 1'b0;
        round++;
        if (round == 1) both = 1;
      end
    end
    nChk++;
    if (grants.size() != 4) begin nFail++; $display("FAIL contention_grant_count: got %0d expected 4", grants.size()); end
    for (int k = 0; k < 4 && k < grants.size(); k++) begin
      nChk++;
      if (grants[k] !== expG[k]) begin nFail++; $display("FAIL contention_order k=%0d: got %h expected %h", k, grants[k], expG[k]); end
    end
    nChk++;
    if (firstDDone != 9 || iStart != 11) begin
      nFail++; $display("FAIL contention_timing: got d_done=%0d i_start=%0d expected 9 11", firstDDone, iStart);
    end
    nChk++;
    if (dRv != 16 || iRv != 16) begin nFail++; $display("FAIL contention_words: got d=%0d i=%0d expected 16 16", dRv, iRv); end
  endtask

  task automatic test_write_back;
    int ackCnt = 0, wnextCnt = 0, doneCnt = 0, rvCnt = 0, doneCycle = -1;
    apply_reset;
    ackMode = 3;
    bus.d_we = 1'b1;
    bus.d_addr = 32'h4010;
    bus.d_wdata = 32'hB000_0000;
    bus.d_req = 1'b1;
    for (int c = 1; c <= 60 && (doneCycle < 0 || c <= doneCycle + 2); c++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        nChk++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'h4000 + 32'(4 * ackCnt), bus.d_wdata}) begin
          nFail++;
          $display("FAIL write_back_bus c=%0d: got we=%b addr=%h wdata=%h expected we=1 addr=%h wdata=%h",
                   c, bus.mem_we, bus.mem_addr, bus.mem_wdata, 32'h4000 + 32'(4 * ackCnt), bus.d_wdata);
        end
      end
      if (bus.mem_ack) begin
        nChk++;
        if (bus.mem_wdata !== 32'hB000_0000 + 32'(ackCnt)) begin
          nFail++; $display("FAIL write_back_word c=%0d: got %h expected %h", c, bus.mem_wdata, 32'hB000_0000 + 32'(ackCnt));
        end
        ackCnt++;
      end
      if (bus.d_wnext) begin wnextCnt++; bus.d_wdata = 32'hB000_0000 + 32'(wnextCnt); end
      if (bus.d_rvalid || bus.i_rvalid) rvCnt++;
      if (bus.d_done) begin doneCnt++; doneCycle = c; bus.d_req = 1'b0; end
    end
    nChk++;
    if (wnextCnt != 8 || doneCnt != 1 || rvCnt != 0) begin
      nFail++; $display("FAIL write_back_counts: got wnext=%0d done=%0d rvalid=%0d expected 8 1 0", wnextCnt, doneCnt, rvCnt);
    end
    nChk++;
    if (doneCycle != 25) begin nFail++; $display("FAIL write_back_done_cycle: got %0d expected 25", doneCycle); end
    ackMode = 1;
  endtask

  task automatic test_starvation;
    logic [31:0] grants[$];
    logic prevReq = 1'b0;
    int iStart = -1;
    bit iDone = 0;
    apply_reset;
    bus.i_addr = 32'h3000;
    bus.d_addr = 32'h2000;
    bus.d_we = 1'b0;
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.mem_req && !prevReq) begin
        grants.push_back(bus.mem_addr);
        if (grants.size() == 2) iStart = c;
      end
      prevReq = bus.mem_req;
      if (bus.i_done) begin iDone = 1; bus.i_req = 1'b0; end
      if (bus.d_done && iDone) bus.d_req = 1'b0;
    end
    nChk++;
    if (grants.size() < 2 || grants[0] !== 32'h2000 || grants[1] !== 32'h3000) begin
      nFail++; $display("FAIL starvation_order: got %0d grants first=%h second=%h expected 2000 3000",
                        grants.size(), grants.size() > 0 ? grants[0] : 32'h0, grants.size() > 1 ? grants[1] : 32'h0);
    end
    nChk++;
    if (iStart != 11) begin nFail++; $display("FAIL starvation_i_start: got %0d expected 11", iStart); end
    nChk++;
    if (bus.busy !== 1'b0) begin nFail++; $display("FAIL starvation_drain: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid_burst;
    int iDoneCycle = -1, rv = 0;
    apply_reset;
    bus.i_addr = 32'h0000_1234;
    bus.i_req = 1'b1;
    repeat (4) @(negedge clk);
    nChk++;
    if (bus.mem_addr !== 32'h122C) begin nFail++; $display("FAIL mid_reset_word3: got %h expected 0000122c", bus.mem_addr); end
    rst = 1'b0;
    #1;
    nChk++;
    if (outs !== '0) begin nFail++; $display("FAIL mid_reset_immediate: got %h expected 0", outs); end
    @(negedge clk);
    nChk++;
    if (outs !== '0) begin nFail++; $display("FAIL mid_reset_held: got %h expected 0", outs); end
    rst = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        nChk++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h1220}) begin
          nFail++; $display("FAIL mid_reset_restart: got req=%b addr=%h expected req=1 addr=00001220", bus.mem_req, bus.mem_addr);
        end
      end
      if (bus.i_rvalid) rv++;
      if (bus.i_done) begin iDoneCycle = c; bus.i_req = 1'b0; end
    end
    nChk++;
    if (iDoneCycle != 9 || rv != 8) begin nFail++; $display("FAIL mid_reset_complete: got done=%0d words=%0d expected 9 8", iDoneCycle, rv); end
  endtask

  task automatic test_stray_ack;
    apply_reset;
    ackMode = 0;
    manualAck = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      nChk++;
      if (outs !== '0) begin nFail++; $display("FAIL stray_ack c=%0d: got %h expected 0", c, outs); end
    end
    manualAck = 1'b0;
    ackMode = 1;
  endtask

  initial begin
    bus.i_req = 1'b0;
    bus.i_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    test_reset;
    test_i_refill;
    test_contention;
    test_write_back;
    test_starvation;
    test_reset_mid_burst;
    test_stray_ack;
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule
